muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair of the pipelined MIPS core. It sits beside the ALU in the EX stage and accepts MULT/MULTU/DIV/DIVU from EX. It runs a 32-step shift-add or restoring-divide loop, then commits HI/LO. While it is busy it stalls the pipeline for any dependent HI/LO access.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// The divide datapath is present only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int ITER = 32;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// The divide branch and its mode input exist only when MULDIV_DIV_EN is defined.
module muldiv_step (
`ifdef MULDIV_DIV_EN
   input  logic        div_mode,
`endif
   input  logic [31:0] acc,
   input  logic [31:0] pair,
   input  logic [31:0] opnd,
   output logic [31:0] acc_nxt,
   output logic [31:0] pair_nxt
);

   logic [32:0] sum;
`ifdef MULDIV_DIV_EN
   logic [32:0] rem_s;
`endif

   // NOTE: every output gets a value before any branch, so no latch can be inferred.
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, (pair[0] ? opnd : 32'd0)};
      acc_nxt  = sum[32:1];
      pair_nxt = {sum[0], pair[31:1]};
`ifdef MULDIV_DIV_EN
      // Remainder stays below the divisor, so the shifted value needs one extra bit.
      rem_s = {acc, pair[31]};
      if (div_mode) begin
         if (rem_s >= {1'b0, opnd}) begin
            acc_nxt  = 32'(rem_s - {1'b0, opnd});
            pair_nxt = {pair[30:0], 1'b1};
         end else begin
            acc_nxt  = rem_s[31:0];
            pair_nxt = {pair[30:0], 1'b0};
         end
      end
`endif
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall generation.
// Define MULDIV_DIV_EN to include DIV/DIVU; otherwise they raise op_err.
module muldiv_seq
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        mf_req,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        dz_err,
   output logic        op_err
);

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] acc, pair, opnd;
   logic        is_signed, sign_q;
`ifdef MULDIV_DIV_EN
   logic        is_div, sign_r, dz;
`endif

   logic        op_signed, op_is_div, supported, accept;
   logic [31:0] acc_nxt, pair_nxt, fix_hi, fix_lo;

   always_comb begin
      op_signed = 1'b0;
      op_is_div = 1'b0;
      case (op)
         OP_MULT:  op_signed = 1'b1;
         OP_MULTU: ;
         OP_DIV:   begin op_signed = 1'b1; op_is_div = 1'b1; end
         OP_DIVU:  op_is_div = 1'b1;
         default:  ;
      endcase
   end

`ifdef MULDIV_DIV_EN
   assign supported = 1'b1;
`else
   assign supported = !op_is_div;
`endif

   assign accept = (state == IDLE) && start && !flush && supported;
   assign busy   = (state != IDLE);
   assign stall  = (start | mf_req | mthi | mtlo) & busy;

   muldiv_step u_step (
`ifdef MULDIV_DIV_EN
      .div_mode (is_div),
`endif
      .acc      (acc),
      .pair     (pair),
      .opnd     (opnd),
      .acc_nxt  (acc_nxt),
      .pair_nxt (pair_nxt)
   );

   // NOTE: these operand registers are fully loaded on accept before any use, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         is_signed <= op_signed;
         sign_q    <= op_signed && (rs_val[31] ^ rt_val[31]);
         acc       <= '0;
`ifdef MULDIV_DIV_EN
         is_div    <= op_is_div;
         sign_r    <= op_signed && rs_val[31];
         dz        <= op_is_div && (rt_val == '0);
         // A zero divisor parks the raw dividend in opnd; FIX returns it as HI.
         if (op_is_div) begin
            pair <= mag(rs_val, op_signed);
            opnd <= (rt_val == '0) ? rs_val : mag(rt_val, op_signed);
         end else
`endif
         begin
            pair <= mag(rt_val, op_signed);
            opnd <= mag(rs_val, op_signed);
         end
      end else if (state == CALC) begin
         acc  <= acc_nxt;
         pair <= pair_nxt;
      end
   end

   always_comb begin
      fix_hi = acc;
      fix_lo = pair;
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         if (dz) begin
            fix_lo = '1;
            fix_hi = opnd;
         end else begin
            if (is_signed && sign_q) fix_lo = -pair;
            if (is_signed && sign_r) fix_hi = -acc;
         end
      end else
`endif
      if (is_signed && sign_q) {fix_hi, fix_lo} = -{acc, pair};
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         dz_err <= 1'b0;
         op_err <= 1'b0;
      end else begin
         done   <= 1'b0;
         dz_err <= 1'b0;
         op_err <= 1'b0;
         case (state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (accept) begin
                  state <= CALC;
                  cnt   <= '0;
               end else if (start && !flush && !supported) begin
                  op_err <= 1'b1;
               end
            end
            CALC: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'(ITER - 1)) state <= FIX;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!flush) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  done <= 1'b1;
`ifdef MULDIV_DIV_EN
                  dz_err <= dz;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random ops against a 64-bit arithmetic model.
// Follows the DUT build: with MULDIV_DIV_EN undefined, DIV/DIVU are expected to raise op_err.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, mthi, mtlo, mf_req, flush;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val, wdata;
   logic [31:0] hi, lo;
   logic        busy, stall, done, dz_err, op_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_seq dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mf_req(mf_req), .flush(flush),
      .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .dz_err(dz_err), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference result computed with plain 64-bit arithmetic.
   task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output bit rdz, output bit rerr);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      rhi = exp_hi; rlo = exp_lo; rdz = 0; rerr = 0;
`ifndef MULDIV_DIV_EN
      if (o == OP_DIV || o == OP_DIVU) begin
         rerr = 1;
         return;
      end
`endif
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         OP_MULT:  begin p = 64'(sa * sb); {rhi, rlo} = p; end
         OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {rhi, rlo} = p; end
         default: begin
            if (b == 0) begin
               rdz = 1; rlo = 32'hFFFF_FFFF; rhi = a;
            end else if (o == OP_DIV) begin
               sq = sa / sb; sr = sa % sb;
               rlo = sq[31:0]; rhi = sr[31:0];
            end else begin
               rlo = a / b; rhi = a % b;
            end
         end
      endcase
   endtask

   // Called at negedge+1; returns at negedge+1 of the done cycle so a following call issues back-to-back.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit mf, input bit wr, input bit mt);
      logic [31:0] ehi, elo;
      bit          edz, eerr, hold_chk;
      int          cyc;
      if (mt) exp_lo = 32'hA5A5_5A5A;
      ref_op(o, a, b, ehi, elo, edz, eerr);
      op = o; rs_val = a; rt_val = b; start = 1;
      if (mt) begin mtlo = 1; wdata = 32'hA5A5_5A5A; end
      @(negedge clk);
      start = 0; mtlo = 0; mf_req = mf;
      #1;
      check("done_one_cycle", done, 0);
      if (mt) check("mtlo_with_start", lo, 32'hA5A5_5A5A);
      if (eerr) begin
         check("op_err_pulse", op_err, 1);
         check("busy_on_op_err", busy, 0);
         @(negedge clk); #1;
         check("op_err_clears", op_err, 0);
         check("hi_after_op_err", hi, exp_hi);
         check("lo_after_op_err", lo, exp_lo);
         mf_req = 0;
         return;
      end
      cyc = 0; hold_chk = 0;
      for (int i = 0; i < 40 && done !== 1'b1; i++) begin
         if (hold_chk) begin check("hi_hold_busy", hi, exp_hi); hold_chk = 0; end
         if (busy === 1'b1) cyc++;
         if (mf) check("stall_mf", stall, 1);
         if (wr && cyc == 5) begin
            mthi = 1; wdata = ~exp_hi;
            #1 check("stall_mthi", stall, 1);
            hold_chk = 1;
         end
         @(negedge clk);
         mthi = 0;
         #1;
      end
      check("done_seen", done, 1);
      check("busy_cycles", cyc, 33);
      check("hi_result", hi, ehi);
      check("lo_result", lo, elo);
      check("dz_err", dz_err, edz);
      check("busy_in_done", busy, 0);
      if (mf) check("stall_in_done", stall, 0);
      mf_req = 0;
      exp_hi = ehi; exp_lo = elo;
   endtask

   task automatic flush_test();
      int done_cnt = 0;
      op = OP_MULTU; rs_val = 32'h1234; rt_val = 32'h10; start = 1;
      @(negedge clk); start = 0;
      repeat (19) @(negedge clk);
      flush = 1;
      @(negedge clk); flush = 0; #1;
      check("busy_after_flush", busy, 0);
      check("hi_after_flush", hi, exp_hi);
      check("lo_after_flush", lo, exp_lo);
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      check("no_done_after_flush", done_cnt, 0);
      #1;
   endtask

   task automatic reset_mid_calc();
      op = OP_MULT; rs_val = 32'd77; rt_val = 32'd91; start = 1;
      @(negedge clk); start = 0; mf_req = 1;
      repeat (10) @(negedge clk);
      #2 rst = 1;
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst = 0; mf_req = 0;
      exp_hi = '0; exp_lo = '0;
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; start = 0; op = '0; rs_val = '0; rt_val = '0;
      mthi = 0; mtlo = 0; wdata = '0; mf_req = 0; flush = 0;
      #12;
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_busy", busy, 0);
      check("reset_stall", stall, 0);
      check("reset_done", done, 0);
      check("reset_dz_err", dz_err, 0);
      check("reset_op_err", op_err, 0);
      @(negedge clk); rst = 0; #1;

      mthi = 1; wdata = 32'h1111_2222;
      @(negedge clk); mthi = 0; mtlo = 1; wdata = 32'h3333_4444;
      @(negedge clk); mtlo = 0; #1;
      check("mthi_idle", hi, 32'h1111_2222);
      check("mtlo_idle", lo, 32'h3333_4444);
      exp_hi = 32'h1111_2222; exp_lo = 32'h3333_4444;

      run_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1, 0, 0);
      run_op(OP_DIVU,  32'd100, 32'd7, 0, 1, 0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      run_op(OP_DIV,   32'd5, 32'd0, 0, 0, 0);
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
      run_op(OP_DIVU,  32'h8000_0001, 32'd0, 0, 0, 1);
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1, 1);

      flush_test();
      run_op(OP_MULT, 32'h0001_2345, 32'hFFFF_F000, 0, 0, 0);
      reset_mid_calc();

      for (int n = 0; n < 24; n++) begin
         logic [31:0] a, b;
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = $urandom_range(0, 255);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         run_op(2'($urandom_range(0, 3)), a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), 0);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
